// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer -- control block of the TTRPG dice roller.
//
// Debounces the seven die buttons, grants one roll at a time to the lowest
// pressed die, runs the IDLE/ROLLING/SHOW sequence with a free-running BCD
// counter that wraps at the die maximum, and schedules the two-digit common
// multiplexing for the 7-segment display.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   design selected; low forces IDLE, blank digits, commons off
//   btn[6:0] in   active-high buttons: d4, d6, d8, d10, d12, d20, d100
//   digit1   out  ones digit, BCD 0-9, 15 = blank
//   digit10  out  tens digit, BCD 0-9, 15 = blank
//   com1     out  ones-digit common enable, active-high
//   com10    out  tens-digit common enable, active-high
//   busy     out  high while rolling
//   die_sel  out  index 0-6 of the die owning the current or last roll
//
// Optional feature macro: DICE_ROLL_ANIM_EN -- when defined the digits show
// the live counter while rolling; otherwise they stay blank until SHOW.
module dice_roll_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int MIN_ROLL        = 4096,
  parameter int MUX_DIV         = 2048
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] btn,
  output logic [3:0] digit1,
  output logic [3:0] digit10,
  output logic       com1,
  output logic       com10,
  output logic       busy,
  output logic [2:0] die_sel
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RC_W = $clog2(MIN_ROLL + 1);
  localparam int MX_W = $clog2(MUX_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_MIN  = RC_W'(MIN_ROLL);
  localparam logic [MX_W-1:0] MX_LAST = MX_W'(MUX_DIV - 1);
  localparam logic [MX_W-1:0] MX_HALF = MX_W'(MUX_DIV / 2);
  localparam logic [3:0]      BLANK   = 4'd15;

  typedef enum logic [1:0] {IDLE, ROLLING, SHOW} state_t;

  state_t            state, state_n;
  logic [6:0]        sync_p0, sync_p1;
  logic [DB_W-1:0]   db_cnt;
  logic              db_tick;
  logic [6:0]        db_prev, deb, db_stable, db_next, req;
  logic [2:0]        win_idx, sel_n;
  logic [7:0]        cnt, cnt_n;
  logic [RC_W-1:0]   roll_cnt, rc_n;
  logic [7:0]        dig_n;
  logic [MX_W-1:0]   mux_cnt, mux_cnt_n;
  logic              com1_n, com10_n;

  // BCD maximum per die; the d100 maximum is held as 00 (99 rolls over to it).
  function automatic logic [7:0] die_max(input logic [2:0] idx);
    case (idx)
      3'd0:    die_max = 8'h04;
      3'd1:    die_max = 8'h06;
      3'd2:    die_max = 8'h08;
      3'd3:    die_max = 8'h10;
      3'd4:    die_max = 8'h12;
      3'd5:    die_max = 8'h20;
      default: die_max = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [2:0] idx);
    if (v == die_max(idx))
      bcd_step = 8'h01;
    else if (v[3:0] == 4'd9)
      bcd_step = {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
    else
      bcd_step = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Tens blanking: d100 always shows both digits (100 reads as 00); d10 shows
  // its 10 as a lone 0; every other die blanks a zero tens digit.
  function automatic logic [7:0] disp(input logic [7:0] v, input logic [2:0] idx);
    logic [3:0] tens;
    tens = v[7:4];
    if (idx != 3'd6 && (tens == 4'd0 || idx == 3'd3))
      tens = BLANK;
    disp = {tens, v[3:0]};
  endfunction

  // A bit is accepted only when two consecutive ticks agree on it.
  assign db_tick   = (db_cnt == DB_LAST);
  assign db_stable = ~(sync_p1 ^ db_prev);
  assign db_next   = (db_stable & sync_p1) | (~db_stable & deb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db_cnt  <= '0;
      db_prev <= '0;
      deb     <= '0;
      req     <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      db_cnt  <= db_tick ? '0 : db_cnt + 1'b1;
      req     <= '0;
      if (db_tick) begin
        db_prev <= sync_p1;
        deb     <= db_next;
        req     <= db_next & ~deb;
      end
    end
  end

  always_comb begin
    win_idx = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (req[i]) win_idx = 3'(i);
  end

  always_comb begin
    state_n = state;
    sel_n   = die_sel;
    cnt_n   = cnt;
    rc_n    = roll_cnt;
    case (state)
      IDLE, SHOW: begin
        if (|req) begin
          state_n = ROLLING;
          sel_n   = win_idx;
          cnt_n   = 8'h01;
          rc_n    = RC_W'(1);
        end
      end
      ROLLING: begin
        if (!deb[die_sel] && roll_cnt >= RC_MIN) begin
          state_n = SHOW;
        end else begin
          cnt_n = bcd_step(cnt, die_sel);
          if (roll_cnt < RC_MIN) rc_n = roll_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!ena) begin
      state_n = IDLE;
      sel_n   = die_sel;
      cnt_n   = cnt;
      rc_n    = roll_cnt;
    end
  end

  always_comb begin
    dig_n = {BLANK, BLANK};
    if (state_n == SHOW)
      dig_n = disp(cnt_n, sel_n);
`ifdef DICE_ROLL_ANIM_EN
    else if (state_n == ROLLING)
      dig_n = disp(cnt_n, sel_n);
`endif
  end

  // Slot 0 and slot MUX_DIV/2 keep both commons off to avoid ghosting.
  always_comb begin
    mux_cnt_n = (mux_cnt == MX_LAST) ? '0 : mux_cnt + 1'b1;
    com1_n    = ena && (mux_cnt_n != '0) && (mux_cnt_n < MX_HALF);
    com10_n   = ena && (mux_cnt_n > MX_HALF) && (dig_n[7:4] != BLANK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      die_sel <= 3'd0;
      digit1  <= BLANK;
      digit10 <= BLANK;
      busy    <= 1'b0;
      com1    <= 1'b0;
      com10   <= 1'b0;
      mux_cnt <= '0;
    end else begin
      state   <= state_n;
      die_sel <= sel_n;
      digit10 <= dig_n[7:4];
      digit1  <= dig_n[3:0];
      busy    <= (state_n == ROLLING);
      com1    <= com1_n;
      com10   <= com10_n;
      mux_cnt <= mux_cnt_n;
    end
  end

  // Counter values are only consumed after a load on ROLLING entry.
  always_ff @(posedge clk) begin
    cnt      <= cnt_n;
    roll_cnt <= rc_n;
  end

endmodule
